// File: rtl/cic_pkg.sv
// Shared constants for the sinc^N decimator: width derivation and +/-1 input mapping.
package cic_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit growth is N*log2(R*M) on top of the 2-bit signed input sample.
    function automatic int acc_width(input int order, input int dec_rate, input int diff_delay);
        return 2 + order * clog2(dec_rate * diff_delay);
    endfunction

    localparam logic [1:0] X_POS = 2'b01;
    localparam logic [1:0] X_NEG = 2'b11;

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: y = x - x[n-M] at the decimated rate; combinational subtract, delay line advances on tick_i.
// No internal latency; no backpressure (advances whenever tick_i is high).
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_i,
    input  logic signed [WIDTH-1:0] din_i,
    output logic signed [WIDTH-1:0] dout_o
);

    logic signed [WIDTH-1:0] dly_q [DELAY];
    logic signed [WIDTH-1:0] dly_d [DELAY];

    assign dout_o = din_i - dly_q[DELAY-1];

    always_comb begin
        dly_d = dly_q;
        if (tick_i) begin
            dly_d[0] = din_i;
            for (int i = 1; i < DELAY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q <= dly_d;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Hogenauer sinc^N decimator: 1-bit bitstream in, sign-extended full-precision sample out every R qualified bits.
// Output registered one clock after the internal tick (two edges after the R-th bit); no backpressure.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int ORDER      = 4,
    parameter int DEC_RATE   = 64,
    parameter int DIFF_DELAY = 1,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 out_valid
);

    localparam int ACC_WIDTH = acc_width(ORDER, DEC_RATE, DIFF_DELAY);
    localparam int CNT_W     = clog2(DEC_RATE);

    if (OUT_WIDTH < ACC_WIDTH) begin : g_width_check
        $error("cic_decimator: OUT_WIDTH must be at least ACC_WIDTH");
    end

    logic [1:0]                  x_map;
    logic signed [ACC_WIDTH-1:0] x_ext;
    logic signed [ACC_WIDTH-1:0] int_q [ORDER];
    logic signed [ACC_WIDTH-1:0] int_d [ORDER];
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        tick_q, tick_d;
    logic signed [ACC_WIDTH-1:0] comb_chain [ORDER+1];
    logic [OUT_WIDTH-1:0]        data_out_q, data_out_d;
    logic                        out_valid_q, out_valid_d;

    assign x_map = bit_in ? X_POS : X_NEG;
    assign x_ext = ACC_WIDTH'($signed(x_map));

    // Every stage reads its predecessor's registered value; wrap-around is relied upon.
    always_comb begin
        int_d = int_q;
        if (bit_valid) begin
            int_d[0] = int_q[0] + x_ext;
            for (int k = 1; k < ORDER; k++) begin
                int_d[k] = int_q[k] + int_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (bit_valid) begin
            if (cnt_q == CNT_W'(DEC_RATE - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign comb_chain[0] = int_q[ORDER-1];

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (ACC_WIDTH),
            .DELAY (DIFF_DELAY)
        ) u_comb (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick_q),
            .din_i  (comb_chain[k]),
            .dout_o (comb_chain[k+1])
        );
    end

    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = tick_q;
        if (tick_q) begin
            data_out_d = OUT_WIDTH'(comb_chain[ORDER]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                int_q[k] <= '0;
            end
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            int_q       <= int_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for the default sinc^4, R=64, M=1 decimator; expected values are closed-form CIC results.
module tb_cic_decimator;

    localparam int GAIN  = 16777216;  // (R*M)^N = 64^4
    localparam int TR_Y1 = 635376;    // C(64,4): first output of an all-ones start
    localparam int TR_Y2 = 8126496;   // C(128,4) - 4*C(64,4)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [31:0] data_out;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cic_decimator #(
        .ORDER      (4),
        .DEC_RATE   (64),
        .DIFF_DELAY (1),
        .OUT_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cycle(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (data_out !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %0d want 0", data_out);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_const(input logic b, input logic [31:0] expv, input string name);
        int last;
        int nout;
        apply_reset();
        last = -1;
        nout = 0;
        for (int cyc = 0; cyc < 64 * 12; cyc++) begin
            cycle(1'b1, b);
            if (out_valid === 1'b1) begin
                nout++;
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== 64) begin
                        n_bad++;
                        $display("FAIL %s_period: got %0d want 64", name, cyc - last);
                    end
                end
                last = cyc;
                if (nout >= 5) begin
                    n_cmp++;
                    if (data_out !== expv) begin
                        n_bad++;
                        $display("FAIL %s_value: got %0d want %0d", name, $signed(data_out), $signed(expv));
                    end
                end
            end
        end
        n_cmp++;
        if (nout !== 11) begin
            n_bad++;
            $display("FAIL %s_count: got %0d want 11", name, nout);
        end
    endtask

    task automatic test_alternating();
        int nout;
        apply_reset();
        nout = 0;
        for (int cyc = 0; cyc < 64 * 12; cyc++) begin
            cycle(1'b1, cyc[0]);
            if (out_valid === 1'b1) begin
                nout++;
                if (nout >= 6) begin
                    n_cmp++;
                    if (data_out !== 32'd0) begin
                        n_bad++;
                        $display("FAIL alt_value: got %0d want 0", $signed(data_out));
                    end
                end
            end
        end
        n_cmp++;
        if (nout !== 11) begin
            n_bad++;
            $display("FAIL alt_count: got %0d want 11", nout);
        end
    endtask

    task automatic test_sparse();
        int last;
        int nout;
        int qbits;
        int e_cyc;
        apply_reset();
        last  = -1;
        nout  = 0;
        qbits = 0;
        e_cyc = -1000;
        for (int cyc = 0; cyc < 256 * 10; cyc++) begin
            cycle((cyc % 4) == 0, 1'b1);
            if (out_valid === 1'b1) begin
                nout++;
                // Pulse must be seen in the cycle right after the edge that consumed the 64th bit.
                n_cmp++;
                if (cyc - e_cyc !== 1) begin
                    n_bad++;
                    $display("FAIL sparse_latency: got %0d want 1", cyc - e_cyc);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== 256) begin
                        n_bad++;
                        $display("FAIL sparse_period: got %0d want 256", cyc - last);
                    end
                end
                last = cyc;
                if (nout >= 5) begin
                    n_cmp++;
                    if (data_out !== 32'(GAIN)) begin
                        n_bad++;
                        $display("FAIL sparse_value: got %0d want %0d", $signed(data_out), GAIN);
                    end
                end
            end
            if ((cyc % 4) == 0) begin
                qbits++;
                if (qbits % 64 == 0) e_cyc = cyc;
            end
        end
        n_cmp++;
        if (nout !== 10) begin
            n_bad++;
            $display("FAIL sparse_count: got %0d want 10", nout);
        end
    endtask

    task automatic test_wrap();
        int last;
        int nout;
        apply_reset();
        last = -1;
        nout = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            cycle(1'b1, 1'b1);
            if (out_valid === 1'b1) begin
                nout++;
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== 64) begin
                        n_bad++;
                        $display("FAIL wrap_period: got %0d want 64", cyc - last);
                    end
                end
                last = cyc;
                if (nout >= 5) begin
                    n_cmp++;
                    if (data_out !== 32'(GAIN)) begin
                        n_bad++;
                        $display("FAIL wrap_value: out %0d got %0d want %0d", nout, $signed(data_out), GAIN);
                    end
                end
            end
        end
        n_cmp++;
        if (nout !== 312) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want 312", nout);
        end
    endtask

    task automatic test_reset_mid();
        int nout;
        int first_k;
        apply_reset();
        for (int cyc = 0; cyc < 64 * 7 + 30; cyc++) cycle(1'b1, 1'b1);
        n_cmp++;
        if (data_out !== 32'(GAIN)) begin
            n_bad++;
            $display("FAIL mid_pre_value: got %0d want %0d", $signed(data_out), GAIN);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_out !== 32'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_async_clear: got %0d/%b want 0/0", data_out, out_valid);
        end
        @(negedge clk);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        n_cmp++;
        if (data_out !== 32'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_held_in_reset: got %0d/%b want 0/0", data_out, out_valid);
        end
        rst_n   = 1'b1;
        nout    = 0;
        first_k = -1;
        for (int k = 1; k <= 330; k++) begin
            cycle(1'b1, 1'b1);
            if (k == 128) begin
                n_cmp++;
                if (data_out !== 32'(TR_Y1)) begin
                    n_bad++;
                    $display("FAIL mid_hold: got %0d want %0d", $signed(data_out), TR_Y1);
                end
            end
            if (out_valid === 1'b1) begin
                nout++;
                if (nout == 1) begin
                    first_k = k;
                    n_cmp++;
                    if (data_out !== 32'(TR_Y1)) begin
                        n_bad++;
                        $display("FAIL mid_transient_y1: got %0d want %0d", $signed(data_out), TR_Y1);
                    end
                end else if (nout == 2) begin
                    n_cmp++;
                    if (data_out !== 32'(TR_Y2)) begin
                        n_bad++;
                        $display("FAIL mid_transient_y2: got %0d want %0d", $signed(data_out), TR_Y2);
                    end
                end else if (nout == 5) begin
                    n_cmp++;
                    if (data_out !== 32'(GAIN)) begin
                        n_bad++;
                        $display("FAIL mid_settled: got %0d want %0d", $signed(data_out), GAIN);
                    end
                end
            end
        end
        n_cmp++;
        if (first_k !== 65) begin
            n_bad++;
            $display("FAIL mid_first_latency: got %0d want 65", first_k);
        end
        n_cmp++;
        if (nout !== 5) begin
            n_bad++;
            $display("FAIL mid_count: got %0d want 5", nout);
        end
    endtask

    initial begin
        test_reset();
        test_const(1'b1, 32'(GAIN), "ones");
        test_const(1'b0, 32'(-GAIN), "zeros");
        test_alternating();
        test_sparse();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
